// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job arbiter: default word width, controller
// state encoding and requester id constants.
package rsa_pkg;

    localparam int RSA_BITS = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam logic REQ_STIM = 1'b0;
    localparam logic REQ_PB   = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer remembers
// the last accepted requester so the other one wins the next tie.
module rr_arb2
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_reg;

    always_comb begin
        grant_id = REQ_STIM;
        case (req_valid)
            2'b10:   grant_id = REQ_PB;
            2'b11:   grant_id = ~last_reg;
            default: grant_id = REQ_STIM;
        endcase
        grant = 2'b00;
        if (enable && (req_valid != 2'b00)) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Reset value makes requester 0 the winner of the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= REQ_PB;
        end else if (accept) begin
            last_reg <= grant_id;
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one Montgomery exponentiation engine between two requesters.
// Optional watchdog abort enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter
    import rsa_pkg::*;
#(
    parameter int BITS           = RSA_BITS,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*BITS-1:0] req_m,
    input  logic [2*BITS-1:0] req_e,
    input  logic [2*BITS-1:0] req_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [BITS-1:0]   rsp_result,
    output logic              rsp_err,
    output logic [BITS-1:0]   eng_m,
    output logic [BITS-1:0]   eng_e,
    output logic [BITS-1:0]   eng_n,
    output logic              eng_go,
    input  logic              eng_done,
    input  logic [BITS-1:0]   eng_result,
    output logic              busy
);

    arb_state_t state_reg, state_next;

    logic [BITS-1:0] m_slice [2];
    logic [BITS-1:0] e_slice [2];
    logic [BITS-1:0] n_slice [2];

    logic [BITS-1:0] eng_m_reg, eng_e_reg, eng_n_reg;
    logic [BITS-1:0] rsp_result_reg;
    logic            rsp_id_reg;
    logic            eng_go_reg;

    logic [1:0] grant;
    logic       grant_id;
    logic       accept;
    logic       timeout_hit;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            assign m_slice[gi] = req_m[gi*BITS +: BITS];
            assign e_slice[gi] = req_e[gi*BITS +: BITS];
            assign n_slice[gi] = req_n[gi*BITS +: BITS];
        end
    endgenerate

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_reg == IDLE),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |grant;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd_count_reg;
    logic        rsp_err_reg;

    assign timeout_hit = (state_reg == RUN) && !eng_done && (wd_count_reg == WD_LIMIT);
    assign rsp_err     = rsp_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_count_reg <= '0;
        end else if (accept) begin
            wd_count_reg <= '0;
        end else if (state_reg == RUN) begin
            wd_count_reg <= wd_count_reg + 32'd1;
        end
    end

    // Done takes priority over the watchdog when both land in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_reg <= 1'b0;
        end else if (state_reg == RUN) begin
            if (eng_done) begin
                rsp_err_reg <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign rsp_err        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (eng_done || timeout_hit) state_next = RESP;
            RESP: if (rsp_ready) state_next = GAP;
            GAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result datapath; eng_go rises the cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_m_reg      <= '0;
            eng_e_reg      <= '0;
            eng_n_reg      <= '0;
            rsp_result_reg <= '0;
            rsp_id_reg     <= 1'b0;
            eng_go_reg     <= 1'b0;
        end else if (accept) begin
            eng_m_reg  <= m_slice[grant_id];
            eng_e_reg  <= e_slice[grant_id];
            eng_n_reg  <= n_slice[grant_id];
            rsp_id_reg <= grant_id;
            eng_go_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            if (eng_done) begin
                rsp_result_reg <= eng_result;
                eng_go_reg     <= 1'b0;
            end else if (timeout_hit) begin
                rsp_result_reg <= '0;
                eng_go_reg     <= 1'b0;
            end
        end
    end

    assign eng_m      = eng_m_reg;
    assign eng_e      = eng_e_reg;
    assign eng_n      = eng_n_reg;
    assign eng_go     = eng_go_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: behavioural engine (done after 20 go cycles,
// result m^e mod n), per-cycle observable model, directed job scenarios.
module tb_rsa_job_arbiter;

    localparam int BITS = 128;
    localparam int TMO  = 64;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*BITS-1:0] req_m, req_e, req_n;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [BITS-1:0]   rsp_result;
    logic              rsp_err;
    logic [BITS-1:0]   eng_m, eng_e, eng_n;
    logic              eng_go;
    logic              eng_done;
    logic [BITS-1:0]   eng_result;
    logic              busy;

    logic [BITS-1:0] tb_m [2];
    logic [BITS-1:0] tb_e [2];
    logic [BITS-1:0] tb_n [2];

    logic            done_model;
    logic            stray_done;
    logic            eng_en;
    logic [BITS-1:0] eng_result_tb;
    int              eng_cnt;

    int vectors;
    int miscompares;

    assign req_m      = {tb_m[1], tb_m[0]};
    assign req_e      = {tb_e[1], tb_e[0]};
    assign req_n      = {tb_n[1], tb_n[0]};
    assign eng_done   = done_model | stray_done;
    assign eng_result = eng_result_tb;

    rsa_job_arbiter #(.BITS(BITS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_m      (req_m),
        .req_e      (req_e),
        .req_n      (req_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .eng_m      (eng_m),
        .eng_e      (eng_e),
        .eng_n      (eng_n),
        .eng_go     (eng_go),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] modexp(logic [127:0] m, logic [127:0] e, logic [127:0] n);
        longint unsigned b, r, nn;
        if (n == 0) return '0;
        nn = n[63:0];
        b  = m[63:0] % nn;
        r  = 1 % nn;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return 128'(r);
    endfunction

    // Engine: done pulses after 20 consecutive go cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_cnt       <= 0;
            done_model    <= 1'b0;
            eng_result_tb <= '0;
        end else if (eng_go && eng_en) begin
            if (eng_cnt == 19) begin
                done_model    <= 1'b1;
                eng_cnt       <= 0;
                eng_result_tb <= modexp(eng_m, eng_e, eng_n);
            end else begin
                done_model <= 1'b0;
                eng_cnt    <= eng_cnt + 1;
            end
        end else begin
            done_model <= 1'b0;
            eng_cnt    <= 0;
        end
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(int idx, logic [127:0] m, logic [127:0] e, logic [127:0] n);
        tb_m[idx] = m;
        tb_e[idx] = e;
        tb_n[idx] = n;
    endtask

    task automatic wait_rsp(string name);
        int n = 0;
        while (rsp_valid === 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (rsp_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk({name, "_rsp_seen"}, 128'(rsp_valid), 128'd1);
    endtask

    // Observable model, sampled on the falling edge.
    logic            m_busy, m_go, m_valid, m_gap, m_id, m_last, m_err;
    logic [127:0]    m_result, m_m, m_e, m_n;
    int              m_run;

    initial begin
        logic [1:0] exp_ready;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 0; m_go = 0; m_valid = 0; m_gap = 0; m_id = 0; m_err = 0;
                m_last = 1; m_result = 0; m_m = 0; m_e = 0; m_n = 0; m_run = 0;
            end
            exp_ready = 2'b00;
            if (!reset && !m_busy) begin
                case (req_valid)
                    2'b01:   exp_ready = 2'b01;
                    2'b10:   exp_ready = 2'b10;
                    2'b11:   exp_ready = m_last ? 2'b01 : 2'b10;
                    default: exp_ready = 2'b00;
                endcase
            end
            chk("req_ready",  128'(req_ready),  128'(exp_ready));
            chk("eng_go",     128'(eng_go),     128'(m_go));
            chk("busy",       128'(busy),       128'(m_busy));
            chk("rsp_valid",  128'(rsp_valid),  128'(m_valid));
            chk("rsp_id",     128'(rsp_id),     128'(m_id));
            chk("rsp_result", rsp_result,       m_result);
            chk("rsp_err",    128'(rsp_err),    128'(m_err));
            chk("eng_m",      eng_m,            m_m);
            chk("eng_e",      eng_e,            m_e);
            chk("eng_n",      eng_n,            m_n);
            if (!reset) begin
                if (m_go) m_run++;
                if (exp_ready != 2'b00) begin
                    m_busy = 1; m_go = 1; m_run = 0;
                    m_id   = exp_ready[1];
                    m_last = exp_ready[1];
                    m_m = tb_m[exp_ready[1]]; m_e = tb_e[exp_ready[1]]; m_n = tb_n[exp_ready[1]];
                end else if (m_go && eng_done) begin
                    m_go = 0; m_valid = 1; m_result = eng_result; m_err = 0;
`ifdef RSA_ARB_TIMEOUT_EN
                end else if (m_go && m_run == TMO) begin
                    m_go = 0; m_valid = 1; m_result = 0; m_err = 1;
`endif
                end else if (m_valid && rsp_ready) begin
                    m_valid = 0; m_gap = 1;
                end else if (m_gap) begin
                    m_gap = 0; m_busy = 0;
                end
            end
        end
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1; req_valid = 0; rsp_ready = 1; stray_done = 0; eng_en = 1;
        drive(0, 0, 0, 0); drive(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Single job from requester 0
        @(posedge clk); #1 drive(0, 7, 3, 33); req_valid = 2'b01;
        @(posedge clk); #1
        chk("t1_go_next_cycle", 128'(eng_go), 128'd1);
        chk("t1_ready_low_in_run", 128'(req_ready), 128'd0);
        req_valid = 2'b00;
        wait_rsp("t1");
        chk("t1_id", 128'(rsp_id), 128'd0);
        chk("t1_result", rsp_result, 128'd13);
        chk("t1_err", 128'(rsp_err), 128'd0);
        @(posedge clk); #1
        chk("t1_gap_busy", 128'(busy), 128'd1);
        chk("t1_gap_go", 128'(eng_go), 128'd0);
        chk("t1_gap_valid", 128'(rsp_valid), 128'd0);
        @(posedge clk); #1
        chk("t1_idle_busy", 128'(busy), 128'd0);

        // Stray done while idle
        stray_done = 1;
        @(posedge clk); #1 stray_done = 0;
        chk("stray_idle_busy", 128'(busy), 128'd0);
        chk("stray_idle_result", rsp_result, 128'd13);

        // Tie from reset: 0, 1, 0
        reset = 1;
        @(posedge clk); #1 reset = 0;
        drive(0, 2, 10, 1000); drive(1, 7, 3, 33); req_valid = 2'b11;
        wait_rsp("tie1");
        chk("tie1_id", 128'(rsp_id), 128'd0);
        chk("tie1_result", rsp_result, 128'd24);
        wait_rsp("tie2");
        chk("tie2_id", 128'(rsp_id), 128'd1);
        chk("tie2_result", rsp_result, 128'd13);
        wait_rsp("tie3");
        chk("tie3_id", 128'(rsp_id), 128'd0);
        chk("tie3_result", rsp_result, 128'd24);
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1;

        // Back-pressure with pending req1 and a stray done in RESP
        rsp_ready = 0; drive(0, 7, 3, 33); req_valid = 2'b01;
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp("bp");
        @(posedge clk); #1 drive(1, 3, 5, 7); req_valid = 2'b10;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1 stray_done = (i == 20);
            @(negedge clk);
            chk("bp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_result", rsp_result, 128'd13);
            chk("bp_id", 128'(rsp_id), 128'd0);
            chk("bp_ready1", 128'(req_ready), 128'd0);
        end
        @(posedge clk); #1 stray_done = 0; rsp_ready = 1;
        wait_rsp("bp_req1");
        chk("bp_req1_id", 128'(rsp_id), 128'd1);
        chk("bp_req1_result", rsp_result, 128'd5);
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1;

        // Asynchronous reset at cycle 10 of RUN
        drive(0, 2, 10, 1000); req_valid = 2'b01;
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (9) @(posedge clk);
        #2 reset = 1;
        #1
        chk("rst_go", 128'(eng_go), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(rsp_valid), 128'd0);
        @(posedge clk); #1 reset = 0;
        drive(1, 7, 3, 33); req_valid = 2'b10;
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp("post_rst");
        chk("post_rst_id", 128'(rsp_id), 128'd1);
        chk("post_rst_result", rsp_result, 128'd13);
        @(posedge clk); #1;

`ifdef RSA_ARB_TIMEOUT_EN
        // Watchdog abort with a silent engine
        begin
            int run_cycles = 0;
            int n = 0;
            @(posedge clk); #1;
            eng_en = 0; drive(0, 7, 3, 33); req_valid = 2'b01;
            @(posedge clk); #1 req_valid = 2'b00;
            while (rsp_valid !== 1'b1 && n < 300) begin
                @(negedge clk); n++;
                if (eng_go) run_cycles++;
            end
            chk("tmo_run_cycles", 128'(run_cycles), 128'(TMO));
            chk("tmo_err", 128'(rsp_err), 128'd1);
            chk("tmo_result", rsp_result, 128'd0);
            @(posedge clk); #1 eng_en = 1;
        end
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
